// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// The optional periodic mode is enabled by defining BCD_COUNTDOWN_AUTO_RELOAD_EN.
package bcd_countdown_timer_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_countdown_timer_digit_down.sv
// One BCD digit of the down counter: decrements on dec_in and borrows at 0.
// Part of bcd_countdown_timer (see BCD_COUNTDOWN_AUTO_RELOAD_EN in the top).
module bcd_digit_down
    import bcd_countdown_timer_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               dec_in,
    output logic [DIGIT_W-1:0] next_digit,
    output logic               borrow_out
);

    always_comb begin
        next_digit = digit;
        if (dec_in) begin
            next_digit = (digit == '0) ? BCD_MAX_DIGIT : digit - 4'd1;
        end
    end

    assign borrow_out = (digit == '0) && dec_in;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Loadable BCD countdown timer with start/pause/resume control and a done pulse.
// Define BCD_COUNTDOWN_AUTO_RELOAD_EN to make it a periodic timer reloading the last load value.
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [4*DIGITS-1:0]    load_val,
    input  logic                   start,
    input  logic                   pause,
    input  logic                   tick_en,
    output logic [4*DIGITS-1:0]    q,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int W = DIGIT_W * DIGITS;

    state_t         state_reg;
    logic [W-1:0]   q_reg;
    logic           busy_reg;
    logic           done_reg;
    logic           err_reg;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    logic [W-1:0]   reload_reg;
`endif

    logic [W-1:0]   q_dec;
    logic [DIGITS:0] borrow;
    logic [DIGITS-1:0] nibble_ok;
    logic           load_ok;
    logic           terminal;

    // Borrow chain: the unit digit always decrements, the top borrow flags q==0.
    assign borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_down u_digit (
                .digit      (q_reg[gi*DIGIT_W +: DIGIT_W]),
                .dec_in     (borrow[gi]),
                .next_digit (q_dec[gi*DIGIT_W +: DIGIT_W]),
                .borrow_out (borrow[gi+1])
            );
            assign nibble_ok[gi] = (load_val[gi*DIGIT_W +: DIGIT_W] <= BCD_MAX_DIGIT);
        end
    endgenerate

    assign load_ok  = &nibble_ok;
    // Reaching zero on this tick, or already at zero (never wrap to all nines).
    assign terminal = borrow[DIGITS] || (q_dec == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            q_reg      <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
            reload_reg <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, PAUSE, DONE: begin
                    if (load) begin
                        if (load_ok) begin
                            q_reg   <= load_val;
                            err_reg <= 1'b0;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                            reload_reg <= load_val;
`endif
                            if (state_reg == DONE) begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end else if (start && state_reg != DONE) begin
                        if (q_reg != '0) begin
                            state_reg <= RUN;
                            busy_reg  <= 1'b1;
                        end else begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_reg <= PAUSE;
                    end else if (tick_en) begin
                        if (terminal) begin
                            done_reg <= 1'b1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                            if (reload_reg != '0) begin
                                q_reg <= reload_reg;
                            end else begin
                                q_reg     <= '0;
                                state_reg <= DONE;
                                busy_reg  <= 1'b0;
                            end
`else
                            q_reg     <= '0;
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
`endif
                        end else begin
                            q_reg <= q_dec;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign q    = q_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: vector table plus reset and long-count sequences.
// Build with BCD_COUNTDOWN_AUTO_RELOAD_EN defined to exercise the periodic mode instead.
module tb_bcd_countdown_timer;

    localparam int DIGITS = 3;
    localparam int W = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         tick_en = 1'b0;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic         ld;
        logic [W-1:0] lv;
        logic         st;
        logic         pa;
        logic         tk;
        logic [W-1:0] eq;
        logic         eb;
        logic         ed;
        logic         ee;
    } vec_t;

    vec_t vecs[$];

    bcd_countdown_timer #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .tick_en  (tick_en),
        .q        (q),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic ld, input logic [W-1:0] lv, input logic st, input logic pa,
                       input logic tk, input logic [W-1:0] eq, input logic eb, input logic ed,
                       input logic ee);
        vec_t v;
        v.ld = ld; v.lv = lv; v.st = st; v.pa = pa; v.tk = tk;
        v.eq = eq; v.eb = eb; v.ed = ed; v.ee = ee;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs at the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic drive(input logic ld, input logic [W-1:0] lv, input logic st, input logic pa,
                         input logic tk);
        @(negedge clk);
        load = ld; load_val = lv; start = st; pause = pa; tick_en = tk;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] eq, input logic eb,
                             input logic ed, input logic ee);
        check({tag, "_q"}, 32'(q), 32'(eq));
        check({tag, "_busy"}, 32'(busy), 32'(eb));
        check({tag, "_done"}, 32'(done), 32'(ed));
        check({tag, "_err"}, 32'(err), 32'(ee));
        $display("%s: q=%03h busy=%0b done=%0b err=%0b", tag, q, busy, done, err);
    endtask

    initial begin
        // Reset state and asynchronous reset in the middle of a count
        #12;
        check_all("reset", 12'h000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 12'h437, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        check_all("run437", 12'h437, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_all("async_rst", 12'h000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

`ifndef BCD_COUNTDOWN_AUTO_RELOAD_EN
        //  ld  lv       st    pa    tk    q        busy  done  err
        add(1, 12'h003, 0, 0, 0, 12'h003, 0, 0, 0);
        add(0, 12'h000, 1, 0, 0, 12'h003, 1, 0, 0);
        add(0, 12'h000, 0, 0, 1, 12'h002, 1, 0, 0);
        add(0, 12'h000, 0, 0, 1, 12'h001, 1, 0, 0);
        add(0, 12'h000, 0, 0, 1, 12'h000, 0, 1, 0);
        add(0, 12'h000, 0, 0, 1, 12'h000, 0, 0, 0);
        add(0, 12'h000, 1, 0, 0, 12'h000, 0, 0, 0);
        add(1, 12'h100, 0, 0, 0, 12'h100, 0, 0, 0);
        add(0, 12'h000, 1, 0, 0, 12'h100, 1, 0, 0);
        add(0, 12'h000, 0, 0, 1, 12'h099, 1, 0, 0);
        add(0, 12'h000, 0, 0, 1, 12'h098, 1, 0, 0);
        add(0, 12'h000, 0, 1, 0, 12'h098, 1, 0, 0);
        add(1, 12'h050, 0, 0, 0, 12'h050, 1, 0, 0);
        add(0, 12'h000, 1, 0, 0, 12'h050, 1, 0, 0);
        add(0, 12'h000, 0, 0, 1, 12'h049, 1, 0, 0);
        add(0, 12'h000, 0, 0, 1, 12'h048, 1, 0, 0);
        add(0, 12'h000, 0, 0, 1, 12'h047, 1, 0, 0);
        add(0, 12'h000, 0, 1, 1, 12'h047, 1, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 12'h000, 0, 0, 1, 12'h047, 1, 0, 0);
        add(0, 12'h000, 1, 0, 0, 12'h047, 1, 0, 0);
        add(0, 12'h000, 0, 0, 1, 12'h046, 1, 0, 0);
        add(1, 12'h005, 0, 0, 0, 12'h046, 1, 0, 0);
        add(0, 12'h000, 0, 1, 0, 12'h046, 1, 0, 0);
        add(1, 12'h9A0, 0, 0, 0, 12'h046, 1, 0, 1);
        add(1, 12'h005, 0, 0, 0, 12'h005, 1, 0, 0);
        add(1, 12'h000, 1, 0, 0, 12'h000, 1, 0, 0);
        add(0, 12'h000, 1, 0, 0, 12'h000, 0, 1, 0);
        add(0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0);
        add(1, 12'h0F1, 0, 0, 0, 12'h000, 0, 0, 1);
        add(0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 1);
        add(1, 12'h001, 0, 0, 0, 12'h001, 0, 0, 0);
        add(0, 12'h000, 1, 0, 0, 12'h001, 1, 0, 0);
        add(0, 12'h000, 0, 0, 1, 12'h000, 0, 1, 0);
        add(1, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0);
        add(0, 12'h000, 1, 0, 0, 12'h000, 0, 1, 0);
        add(0, 12'h000, 0, 0, 1, 12'h000, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].pa, vecs[i].tk);
            check_all($sformatf("v%0d", i), vecs[i].eq, vecs[i].eb, vecs[i].ed, vecs[i].ee);
        end

        // Full-range period: done exactly 999 ticks after entering RUN
        begin
            int cycles;
            bit seen;
            cycles = 0;
            seen = 1'b0;
            drive(1'b1, 12'h999, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
            while (!seen && cycles < 1100) begin
                drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
                cycles++;
                if (done) seen = 1'b1;
            end
            check("period999", 32'(cycles), 32'd999);
            check("period999_q", 32'(q), 32'h000);
            $display("period999: cycles=%0d q=%03h", cycles, q);
        end
`else
        drive(1'b1, 12'h002, 1'b0, 1'b0, 1'b0);
        check_all("rl_load", 12'h002, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        check_all("rl_start", 12'h002, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
            check_all($sformatf("rl_t%0d", i), (i % 2 == 0) ? 12'h001 : 12'h002, 1'b1,
                      (i % 2 == 1) ? 1'b1 : 1'b0, 1'b0);
        end
`endif

        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
